// File: rtl/clause_bank_pkg.sv
// Shared sizing helpers, reader state encoding and lane slicing for the clause bank.
package clause_bank_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int at_least1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  // LSB of lane k inside the packed wr_idx bus.
  function automatic int lane_lsb(input int lane, input int idx_w);
    return lane * idx_w;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } rd_state_e;

endpackage

// File: rtl/clause_bank_reader.sv
// Dump reader: walks the bank chunk by chunk and presents each over valid/ready.
module clause_bank_reader
  import clause_bank_pkg::*;
#(
  parameter int CHUNKS    = 4,
  parameter int REG_WIDTH = 32,
  parameter int ADDR_W    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic                 clear_mode_i,
  input  logic                 hold_i,
  input  logic                 ready_i,
  input  logic [REG_WIDTH-1:0] ld_word_i,
  output logic                 ld_en_o,
  output logic                 ld_clr_o,
  output logic [ADDR_W-1:0]    ld_addr_o,
  output logic                 valid_o,
  output logic [REG_WIDTH-1:0] data_o,
  output logic [ADDR_W-1:0]    addr_o,
  output logic                 last_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHUNKS - 1);

  rd_state_e             state_q, state_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  clrm_q, clrm_d;
  logic [REG_WIDTH-1:0]  data_q, data_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  xfer;

  assign xfer = valid_q & ready_i;

  // addr_q holds the most recently loaded chunk, so the next load is always addr_q+1.
  assign ld_addr_o = (state_q == STREAM) ? addr_q + ADDR_W'(1) : '0;
  // Mode is latched on the start cycle, but that first load must already honour it.
  assign ld_clr_o  = (state_q == IDLE) ? clear_mode_i : clrm_q;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    last_d  = last_q;
    clrm_d  = clrm_q;
    ld_en_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i && !hold_i) begin
          ld_en_o = 1'b1;
          clrm_d  = clear_mode_i;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer && last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = DONE;
        end else if ((xfer || !valid_q) && !hold_i) begin
          ld_en_o = 1'b1;
        end else if (xfer) begin
          valid_d = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ld_en_o) begin
      data_d  = ld_word_i;
      addr_d  = ld_addr_o;
      last_d  = (ld_addr_o == LAST_ADDR);
      valid_d = 1'b1;
    end
    if (clear_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
      ld_en_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      clrm_q  <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      clrm_q  <= clrm_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign addr_o  = addr_q;
  assign last_o  = last_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);

endmodule

// File: rtl/clause_vector_bank.sv
// Bit-packed clause-fire bank with multi-lane set writes and a streaming dump reader.
module clause_vector_bank
  import clause_bank_pkg::*;
#(
  parameter  int NUM_CLAUSES = 2016,
  parameter  int REG_WIDTH   = 32,
  parameter  int WR_LANES    = 2,
  localparam int CHUNKS      = ceil_div(NUM_CLAUSES, REG_WIDTH),
  localparam int ADDR_W      = at_least1(clog2(CHUNKS)),
  localparam int IDX_W       = at_least1(clog2(NUM_CLAUSES))
) (
  input  logic                      clk,
  input  logic                      rst_flag_n,
  input  logic                      clear,
  input  logic                      wr_hold,
  input  logic [WR_LANES-1:0]       wr_valid,
  input  logic [WR_LANES*IDX_W-1:0] wr_idx,
  input  logic                      rd_start,
  input  logic                      rd_clear_mode,
  input  logic                      rd_hold,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [REG_WIDTH-1:0]      rd_data,
  output logic [ADDR_W-1:0]         rd_addr,
  output logic                      rd_last,
  output logic                      rd_busy,
  output logic                      rd_done,
  output logic                      oor_err
);

  localparam int FLAT_W = CHUNKS * REG_WIDTH;
  localparam int FI_W   = at_least1(clog2(FLAT_W));

  // Flat bit i of the bank is clause i, so chunk c bit b sits at c*REG_WIDTH+b.
  logic [FLAT_W-1:0]                bank_q, bank_d;
  logic                             oor_q, oor_d;
  logic [WR_LANES-1:0][IDX_W-1:0]   lane_idx;
  logic [WR_LANES-1:0]              lane_ok;
  logic                             ld_en, ld_clr;
  logic [ADDR_W-1:0]                ld_addr;
  logic [REG_WIDTH-1:0]             ld_word;

  for (genvar k = 0; k < WR_LANES; k++) begin : g_lane
    assign lane_idx[k] = wr_idx[lane_lsb(k, IDX_W) +: IDX_W];
    assign lane_ok[k]  = 32'(lane_idx[k]) < NUM_CLAUSES;
  end

  // Reader sees the pre-write bank; same-cycle writes land on top of the (possibly cleared) chunk.
  assign ld_word = bank_q[int'(ld_addr) * REG_WIDTH +: REG_WIDTH];

  always_comb begin
    bank_d = bank_q;
    oor_d  = oor_q;
    if (ld_en && ld_clr) bank_d[int'(ld_addr) * REG_WIDTH +: REG_WIDTH] = '0;
    if (!wr_hold) begin
      for (int k = 0; k < WR_LANES; k++) begin
        if (wr_valid[k]) begin
          if (lane_ok[k]) bank_d[FI_W'(lane_idx[k])] = 1'b1;
          else            oor_d = 1'b1;
        end
      end
    end
    if (clear) begin
      bank_d = '0;
      oor_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_flag_n) begin
    if (!rst_flag_n) begin
      bank_q <= '0;
      oor_q  <= 1'b0;
    end else begin
      bank_q <= bank_d;
      oor_q  <= oor_d;
    end
  end

  assign oor_err = oor_q;

  clause_bank_reader #(
    .CHUNKS   (CHUNKS),
    .REG_WIDTH(REG_WIDTH),
    .ADDR_W   (ADDR_W)
  ) u_reader (
    .clk_i       (clk),
    .rst_n_i     (rst_flag_n),
    .clear_i     (clear),
    .start_i     (rd_start),
    .clear_mode_i(rd_clear_mode),
    .hold_i      (rd_hold),
    .ready_i     (rd_ready),
    .ld_word_i   (ld_word),
    .ld_en_o     (ld_en),
    .ld_clr_o    (ld_clr),
    .ld_addr_o   (ld_addr),
    .valid_o     (rd_valid),
    .data_o      (rd_data),
    .addr_o      (rd_addr),
    .last_o      (rd_last),
    .busy_o      (rd_busy),
    .done_o      (rd_done)
  );

endmodule

// File: doc/clause_vector_bank.md
# clause_vector_bank

Parametrised clause-output register bank sitting between the clause evaluation array and the class-sum/readout logic. It accepts up to WR_LANES clause-fire indices per cycle and sets the corresponding bits in a bit-packed bank of REG_WIDTH-bit chunks. On request, it streams the whole bank out, one chunk per beat, over a valid/ready interface. An optional clear-on-read mode empties the bank for the next sample without a separate clear pass.

## Interface
Parameters:
- NUM_CLAUSES, 2016: number of clause bits stored.
- REG_WIDTH, 32: bits per chunk and read beat.
- WR_LANES, 2: parallel write lanes.
- Derived: CHUNKS = ceil(NUM_CLAUSES/REG_WIDTH), ADDR_W = max(1,clog2(CHUNKS)), IDX_W = max(1,clog2(NUM_CLAUSES)).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_flag_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous clear of bank and reader.
- wr_hold  in  1  1 = ignore all writes this cycle.
- wr_valid  in  WR_LANES  per-lane write enable.
- wr_idx  in  WR_LANES*IDX_W  per-lane clause index; lane k at [k*IDX_W +: IDX_W].
- rd_start  in  1  start a full dump.
- rd_clear_mode  in  1  sampled at accepted rd_start; 1 = clear each chunk as it is read.
- rd_hold  in  1  1 = reader loads no new word.
- rd_ready  in  1  downstream accepts beat.
- rd_valid  out  1  beat valid.
- rd_data  out  REG_WIDTH  chunk contents.
- rd_addr  out  ADDR_W  chunk index of current beat.
- rd_last  out  1  current beat is chunk CHUNKS-1.
- rd_busy  out  1  dump in progress.
- rd_done  out  1  one-cycle pulse after final transfer.
- oor_err  out  1  sticky: a write had wr_idx >= NUM_CLAUSES.

## Operation
- Write: for each lane with wr_valid=1, wr_hold=0, and wr_idx < NUM_CLAUSES, set bit wr_idx%REG_WIDTH of chunk wr_idx/REG_WIDTH. Lanes hitting the same chunk or bit OR-merge.
- Out-of-range lane: no bank change; oor_err set until reset or clear.
- Padding bits of the last chunk (index >= NUM_CLAUSES) are always 0.
- Reader states are IDLE, STREAM, and DONE.
- IDLE -> STREAM: rd_start=1, rd_hold=0, clear=0. Load chunk 0 into rd_data, set rd_valid=1, rd_addr=0. Latch rd_clear_mode.
- STREAM transfer: rd_valid & rd_ready.
  - On transfer, if not last and rd_hold=0: load the next chunk in the same cycle, so rd_valid stays 1.
  - On transfer, if not last and rd_hold=1: rd_valid drops to 0. Load the next chunk on the first cycle with rd_hold=0.
- Transfer of the last beat -> DONE. DONE lasts one cycle with rd_done=1, then returns to IDLE.
- rd_data, rd_addr, and rd_last stay stable while rd_valid & !rd_ready.
- rd_start is ignored while rd_busy=1.
- Clear mode: the chunk is zeroed in the same cycle it is loaded into rd_data.
- Write vs read, same chunk, same cycle: the loaded word is the pre-write value.
  - The bank keeps the write, with write bits set on top of the old value, or on zero in clear mode.
- clear has top priority: zero bank and oor_err, reader -> IDLE, rd_valid=0, no rd_done.

## Timing
- Reset values: rd_valid, rd_data, rd_addr, rd_last, rd_busy, rd_done, and oor_err are all 0; bank is all 0.
- Write latency is 1 cycle. A bit written in cycle N is visible to a reader load in cycle N+1.
- rd_start accepted in cycle 0 gives rd_valid=1 for chunk 0 in cycle 1.
- With rd_ready=1 and rd_hold=0, beats occupy cycles 1..CHUNKS and rd_done pulses in cycle CHUNKS+1.
- rd_busy=1 from cycle 1 until and including the rd_done cycle.
- rst_flag_n low mid-stream aborts immediately to reset values.

## Structure
- Package clause_bank_pkg holds:
  - the clog2/ceil-div constant functions;
  - the reader state enum (IDLE/STREAM/DONE);
  - the lane index slicing helper.
- Sub-module clause_bank_reader holds the reader FSM, address counter, output register, and handshake. The bank array and write-merge logic stay in the top.

## Test plan
Bench parameters: NUM_CLAUSES=100, REG_WIDTH=32, WR_LANES=2, so CHUNKS=4.
- Write idx 0, 33, and 99 (lanes 0/1 over 2 cycles), then dump with rd_ready=1. Required beats: 0x00000001, 0x00000002, 0x00000000, 0x00000008. rd_last on beat 3; rd_done one cycle later.
- Both lanes write idx 5 and 6 in one cycle. Chunk 0 reads 0x00000060.
- Write idx 100 and idx 127. oor_err=1 and all chunks read 0. clear then returns oor_err to 0.
- Clear-mode dump with rd_ready toggling 1,0,1,0. Beats are stable while not ready; a second dump returns all zeros.
- During a clear-mode dump, write idx 40 in the cycle chunk 1 loads. The beat reads the old value, and a second dump gives chunk 1 = 0x00000100.
- Assert rd_hold for 3 cycles after beat 1 transfers: rd_valid stays 0 for 3 cycles. Assert rst_flag_n=0 mid-dump: all outputs go to 0 immediately.
